sfifo_wr_arbiter: RTL

Round-robin write-side arbiter that shares the single write port of one `sfifo` instance among `NREQ` valid/ready producers. It grants one producer at a time and holds the grant until that producer ends a packet or uses up its beat budget. Beats pass straight through to the FIFO write port with no extra buffering. It sits directly in front of the FIFO's `i_wr`/`i_data` and watches `o_full`.

---
 rtl/sfifo_wr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/sfifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// sfifo_wr_arbiter : round-robin, burst-limited write-port arbiter for sfifo
// Revision: 1.0
// ============================================================================
module sfifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int BW       = 8,
    parameter int MAXBURST = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*BW-1:0]   i_req_data,
    input  logic [NREQ-1:0]      i_req_last,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_fifo_wr,
    output logic [BW-1:0]        o_fifo_data,
    input  logic                 i_fifo_full,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST + 1) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      state;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;
    logic [CW-1:0]   beat_cnt;
    logic [NREQ-1:0] grant;
    logic [BW-1:0]   gnt_data;
    logic            gnt_valid;
    logic            gnt_last;
    logic            busy;
    logic            accept;
    logic            release_now;

    assign busy = (state == ST_GRANT);

    // Scan downward so the lowest offset after last_idx is written last and wins.
    always_comb begin
        pick_idx = last_idx;
        scan_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = IW'((int'(last_idx) + k) % NREQ);
            if (i_req_valid[scan_idx]) begin
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_data    = '0;
        gnt_valid   = 1'b0;
        gnt_last    = 1'b0;
        o_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                gnt_data       = i_req_data[i*BW +: BW];
                gnt_valid      = i_req_valid[i];
                gnt_last       = i_req_last[i];
                o_req_ready[i] = busy & ~i_fifo_full;
            end
        end
    end

    assign accept      = busy & gnt_valid & ~i_fifo_full;
    assign release_now = accept & (gnt_last | (beat_cnt == CW'(MAXBURST - 1)));

    assign o_fifo_wr   = accept;
    assign o_fifo_data = busy ? gnt_data : '0;
    assign o_grant     = grant;
    assign o_busy      = busy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            gnt_idx  <= '0;
            last_idx <= IW'(NREQ - 1);
            beat_cnt <= '0;
            grant    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|i_req_valid) begin
                        gnt_idx  <= pick_idx;
                        beat_cnt <= '0;
                        grant    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        // Clearing here keeps beat_cnt within MAXBURST-1.
                        state    <= ST_IDLE;
                        last_idx <= gnt_idx;
                        grant    <= '0;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
